// File: rtl/csa_rr_share_arbiter.sv
// ----------------------------------------------------------------------------
// csa_rr_share_arbiter
//   Shares one 32-bit gate-level carry-select adder between NREQ requesters.
//   A round-robin arbiter picks one valid requester per cycle, feeds its
//   operands to the adder, and captures sum/carry-out plus the requester ID
//   in a single-entry response register drained by a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      requester i has an operand pair
//   req_ready  [NREQ]      requester i accepted this cycle (one-hot or zero)
//   req_a      [NREQ*32]   operand A, requester i in bits [32*i +: 32]
//   req_b      [NREQ*32]   operand B, same packing
//   rsp_valid              response register holds a result
//   rsp_ready              consumer takes the response this cycle
//   rsp_sum    [32]        registered adder sum
//   rsp_cout               registered adder carry-out
//   rsp_id     [ID_W]      requester that produced the response
//
// Also contains the adder itself (bitcarryselectgatelevel) and its
// building blocks so the file is self-contained.
// ----------------------------------------------------------------------------

// One-bit full adder built from gate primitives.
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic axb, ab, cx;

    xor g_x0 (axb, a, b);
    xor g_x1 (s, axb, cin);
    and g_a0 (ab, a, b);
    and g_a1 (cx, axb, cin);
    or  g_o0 (co, ab, cx);
endmodule

// W-bit ripple-carry block made of full-adder lanes.
module csa_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        csa_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .cin(c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];
endmodule

// 32-bit carry-select adder, no carry-in. Block 0 ripples directly; every
// higher block precomputes both carry-in cases and the incoming block carry
// selects between them, so the critical path is one block ripple plus a
// chain of muxes.
module bitcarryselectgatelevel #(
    parameter int W   = 32,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int NBLK = W / BLK;

    // c_blk[g] is the carry into block g
    logic [NBLK:1] c_blk;

    csa_rca #(.W(BLK)) u_rca_blk0 (
        .a  (a[BLK-1:0]),
        .b  (b[BLK-1:0]),
        .cin(1'b0),
        .s  (sum[BLK-1:0]),
        .co (c_blk[1])
    );

    for (genvar g = 1; g < NBLK; g++) begin : g_blk
        logic [BLK-1:0] s0, s1;
        logic           co0, co1;

        csa_rca #(.W(BLK)) u_rca_c0 (
            .a  (a[g*BLK +: BLK]),
            .b  (b[g*BLK +: BLK]),
            .cin(1'b0),
            .s  (s0),
            .co (co0)
        );

        csa_rca #(.W(BLK)) u_rca_c1 (
            .a  (a[g*BLK +: BLK]),
            .b  (b[g*BLK +: BLK]),
            .cin(1'b1),
            .s  (s1),
            .co (co1)
        );

        assign sum[g*BLK +: BLK] = c_blk[g] ? s1 : s0;
        // co1 is always >= co0, so the select reduces to an AND-OR
        assign c_blk[g+1] = co0 | (co1 & c_blk[g]);
    end

    assign cout = c_blk[NBLK];
endmodule

module csa_rr_share_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2   // must equal $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [ID_W-1:0]      rsp_id
);
    localparam int              DW      = 32;
    localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_sum_q,   rsp_sum_d;
    logic            rsp_cout_q,  rsp_cout_d;
    logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
    logic [ID_W-1:0] ptr_q,       ptr_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   scan;
    logic            can_accept;
    logic            fire;
    logic [DW-1:0]   add_a, add_b, add_sum;
    logic            add_cout;

    // Rotating priority scan starting at ptr_q. The extra bit on scan lets
    // the wrap be a single conditional subtract, which also works for NREQ
    // values that are not a power of two.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[ID_W-1:0];
            end
        end
    end

    // Draining and refilling in the same cycle is allowed.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign fire       = gnt_found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign add_a = req_a[gnt_idx*DW +: DW];
    assign add_b = req_b[gnt_idx*DW +: DW];

    bitcarryselectgatelevel #(.W(DW), .BLK(4)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .cout(add_cout)
    );

    // EMPTY/FULL is carried entirely by rsp_valid_q.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_id_d    = gnt_idx;
            ptr_d       = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_csa_rr_share_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for csa_rr_share_arbiter: directed stimulus pushes hand-computed
// responses into a scoreboard queue; a negedge monitor pops and compares each
// response as it is drained. Handshake, stall and reset behaviour are checked
// directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_csa_rr_share_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     sum;
        logic            cout;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a = '0;
    logic [NREQ*32-1:0]  req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;
    logic [ID_W-1:0]     rsp_id;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    csa_rr_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_id   (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [31:0] sum, input logic cout);
        exp_t e;
        e.id   = id;
        e.sum  = sum;
        e.cout = cout;
        sb.push_back(e);
    endtask

    // Monitor: a response transfers at the next rising edge when valid and
    // ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%h cout=%0d with no expected entry",
                         rsp_id, rsp_sum, rsp_cout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_{id,sum,cout}", {29'd0, rsp_id, rsp_sum, rsp_cout},
                    {29'd0, e.id, e.sum, e.cout});
            end
        end
    end

    // Test-3 operand table and hand-computed results
    logic [31:0] t3_a   [NREQ] = '{32'h00000005, 32'hFFFFFFFF, 32'h12345678, 32'hF0000000};
    logic [31:0] t3_b   [NREQ] = '{32'h00000007, 32'h00000001, 32'h87654321, 32'h20000000};
    logic [31:0] t3_sum [NREQ] = '{32'h0000000C, 32'h00000000, 32'h99999999, 32'h10000000};
    logic        t3_co  [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // ---- reset ----
        tick();
        tick();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("reset_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        req_valid = 4'hF;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // ---- test 1: single request from requester 0 ----
        rsp_ready = 1'b1;
        set_op(0, 32'h00000001, 32'h00000001);
        req_valid = 4'b0001;
        push(2'd0, 32'h00000002, 1'b0);
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        #1;
        chk("t1_req_ready_drop", 64'(req_ready), 64'd0);

        // ---- test 2: requester 2 then requester 1 ----
        tick();
        set_op(2, 32'hFFFF0006, 32'h12560006);
        req_valid = 4'b0100;
        push(2'd2, 32'h1255000C, 1'b1);
        #1;
        chk("t2_req_ready_r2", 64'(req_ready), 64'b0100);
        tick();
        set_op(1, 32'hFEFEF1EF, 32'hFEFEF1EF);
        req_valid = 4'b0010;
        push(2'd1, 32'hFDFDE3DE, 1'b1);
        #1;
        chk("t2_req_ready_r1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;

        // ---- test 5: requester 3 alone, then 0 and 3 (pointer wraps) ----
        set_op(3, 32'h80000000, 32'h80000000);
        req_valid = 4'b1000;
        push(2'd3, 32'h00000000, 1'b1);
        #1;
        chk("t5_req_ready_r3", 64'(req_ready), 64'b1000);
        tick();
        set_op(0, 32'h7FFFFFFF, 32'h00000001);
        set_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        req_valid = 4'b1001;
        push(2'd0, 32'h80000000, 1'b0);
        #1;
        chk("t5_req_ready_wrap0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b1000;
        push(2'd3, 32'hFFFFFFFE, 1'b1);
        #1;
        chk("t5_req_ready_then3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;

        // ---- test 3: all requesters valid, 8 back-to-back grants ----
        for (int i = 0; i < NREQ; i++) set_op(i, t3_a[i], t3_b[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            push(ID_W'(k % NREQ), t3_sum[k % NREQ], t3_co[k % NREQ]);
            #1;
            chk("t3_rr_grant", 64'(req_ready), 64'(1 << (k % NREQ)));
            tick();
        end
        req_valid = '0;

        // ---- test 4: backpressure then same-cycle drain and refill ----
        req_valid = 4'b0001;
        push(2'd0, 32'h0000000C, 1'b0);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_req_ready", 64'(req_ready), 64'd0);
            chk("t4_stall_rsp", {30'd0, rsp_valid, rsp_id, rsp_sum},
                {30'd0, 1'b1, 2'd0, 32'h0000000C});
            tick();
        end
        rsp_ready = 1'b1;
        push(2'd1, 32'h00000000, 1'b1);
        #1;
        chk("t4_refill_r1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1000;
        chk("t4_valid_kept", 64'(rsp_valid), 64'd1);
        push(2'd3, 32'h10000000, 1'b1);
        #1;
        chk("t4_refill_r3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        tick();

        // ---- test 6: reset while a response is stalled ----
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'hF;
        #1;
        chk("t6_stalled", {61'd0, rsp_valid, rsp_id}, {61'd0, 1'b1, 2'd2});
        chk("t6_stall_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_req_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        chk("t6_post_rst_rsp", {29'd0, rsp_valid, rsp_id, rsp_sum, rsp_cout}, 64'd0);
        rsp_ready = 1'b1;
        push(2'd0, 32'h0000000C, 1'b0);
        #1;
        chk("t6_first_grant_r0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;

        // ---- drain scoreboard with a bounded wait ----
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_rr_share_arbiter.md
Name: csa_rr_share_arbiter

Overview:
Shares one instance of the team's 32-bit gate-level carry-select adder (bitcarryselectgatelevel: a, b -> sum, cout) between NREQ requesters.
- Requesters present operands with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and drives its operands into the adder.
- The adder outputs are captured in a single-entry response register, tagged with the requester ID, and drained with a valid/ready handshake.
- The block sits between the ALU-issue logic and the shared adder.

Parameters:
NREQ, 4, number of requesters (2..8).
ID_W, 2, response ID width; must equal clog2(NREQ).

Ports:
clk  input  1  rising-edge clock; sole clock domain.
rst  input  1  reset, synchronous, active-high.
req_valid  input  NREQ  bit i: requester i has an operand pair.
req_ready  output  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
req_a  input  NREQ*32  operand A; requester i in bits [32*i+31:32*i].
req_b  input  NREQ*32  operand B; same packing as req_a.
rsp_valid  output  1  response register holds a result.
rsp_ready  input  1  consumer takes the response this cycle.
rsp_sum  output  32  registered adder sum.
rsp_cout  output  1  registered adder carry-out.
rsp_id  output  ID_W  index of the requester that produced the response.

Behaviour:
- Reset (sampled at the rising edge while rst=1): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, RR pointer ptr=0. Any held response is discarded. req_ready is 0 throughout the reset cycle.
- States (implicit in rsp_valid):
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready. This permits same-cycle drain and refill.
- Arbitration (combinational):
  - Scan requesters ptr, ptr+1, ..., wrapping mod NREQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i] = granted[i] & can_accept & !rst.
  - No request valid -> req_ready all 0.
- Adder use:
  - Exactly one adder instance, a = req_a[granted], b = req_b[granted].
  - Full 32-bit unsigned add, no carry-in; carry-out is reported in rsp_cout.
- Handshake completion at a clock edge with req_valid[i] & req_ready[i]:
  - rsp_sum <= sum, rsp_cout <= cout, rsp_id <= i, rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Drain at a clock edge with rsp_valid & rsp_ready and no new grant: rsp_valid <= 0.
- Both drain and grant at the same edge: the new result replaces the old one and rsp_valid stays 1.
- Backpressure: while rsp_valid & !rsp_ready, rsp_sum, rsp_cout and rsp_id stay stable and req_ready stays all 0.
- Latency: a request accepted at edge N appears on the rsp_* outputs in the cycle after edge N (1 cycle).
- Throughput: 1 result/cycle while rsp_ready=1.
- The pointer advances only on a grant. Idle cycles and stalls do not move ptr.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,..,NREQ-1,0,...
- Starvation bound: a continuously valid requester is granted within NREQ accepted transactions.
- Requesters hold operands stable until their ready. If a requester withdraws valid before grant, the arbiter skips it without error; it samples operands only at handshake.
- rst asserted mid-stall: the pending response is lost, rsp_valid=0 on the next cycle, and arbitration restarts at requester 0.

Test Plan:
1. Reset, then only requester 0 valid with a=0x00000001, b=0x00000001, rsp_ready=1 -> req_ready[0]=1 for one cycle; next cycle rsp_valid=1, rsp_sum=0x00000002, rsp_cout=0, rsp_id=0.
2. Requester 2 sends a=0xFFFF0006, b=0x12560006 -> rsp_sum=0x1255000C, rsp_cout=1, rsp_id=2. Then requester 1 sends a=0xFEFEF1EF, b=0xFEFEF1EF -> rsp_sum=0xFDFDE3DE, rsp_cout=1, rsp_id=1.
3. All 4 requesters valid continuously with distinct operands, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; one response per cycle; each sum matches a+b mod 2^32.
4. Response held with rsp_ready=0 for 5 cycles while requesters 1 and 3 are valid -> rsp_* stable and req_ready=0 for all 5 cycles. Raise rsp_ready -> same-cycle drain and refill, rsp_valid stays 1, next rsp_id=1 then 3.
5. Requester 3 only, granted; then requesters 0 and 3 valid -> requester 0 granted first (ptr wrapped to 0), then 3.
6. rst pulsed for 1 cycle while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, rsp_sum=0, rsp_id=0; with all requesters valid, the first post-reset grant goes to requester 0.
